imem_arbiter: RTL and testbench

- Shares one single-port, 1-cycle-latency synchronous instruction memory between two requesters.
- The core fetch port has fixed priority. The program loader port (boot/debug writer) may read or write.
- Sits between the fetch stage / loader and the instruction RAM that replaces the combinational ROM.
- Owns arbitration, the starvation guard, response routing and misaligned-fetch handling.

---
 rtl/imem_arb_pkg.sv | 18 +
 rtl/imem_starve_ctr.sv | 28 ++
 rtl/imem_arbiter.sv | 126 ++++++++++++
 tb/tb_imem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_arb_pkg;

   typedef enum logic [2:0] {
      NONE,
      FETCH,
      FETCH_MIS,
      LD_RD,
      LD_WR
   } resp_owner_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive denied loader cycles; raises force_ld at the limit.
module imem_starve_ctr #(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ld_req,
   input  logic ld_gnt,
   output logic force_ld
);

   localparam logic [7:0] LIMIT = 8'(STARVE_MAX);

   logic [7:0] starve_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!ld_req || ld_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end

   assign force_ld = ld_req && (starve_cnt == LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter for a single-port 1-cycle synchronous instruction RAM.
// Optional write protection (wr_lock/ld_err) is enabled with IMEM_WR_PROTECT_EN.
module imem_arbiter #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned STARVE_MAX  = 8,
   parameter logic [31:0] NOP_INSTR   = imem_arb_pkg::NOP_INSTR,
   localparam int unsigned IDX_W      = imem_arb_pkg::idx_w(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_req,
   input  logic [31:0]      fetch_addr,
   output logic             fetch_gnt,
   output logic             fetch_rvalid,
   output logic [31:0]      fetch_rdata,
   output logic             fetch_err,
   input  logic             ld_req,
   input  logic             ld_we,
   input  logic [31:0]      ld_addr,
   input  logic [31:0]      ld_wdata,
   output logic             ld_gnt,
   output logic             ld_rvalid,
   output logic [31:0]      ld_rdata,
`ifdef IMEM_WR_PROTECT_EN
   input  logic             wr_lock,
   output logic             ld_err,
`endif
   output logic             mem_en,
   output logic             mem_we,
   output logic [IDX_W-1:0] mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   import imem_arb_pkg::*;

   resp_owner_e      owner_d, owner_q;
   logic             force_ld;
   logic             fetch_mis;
   logic [IDX_W-1:0] fetch_idx, ld_idx;
   logic             unused_addr_bits;

   assign fetch_idx = fetch_addr[IDX_W+1:2];
   assign ld_idx    = ld_addr[IDX_W+1:2];
   assign fetch_mis = (fetch_addr[1:0] != 2'b00);
   assign unused_addr_bits = ^{fetch_addr[31:IDX_W+2], ld_addr[31:IDX_W+2], ld_addr[1:0]};

   imem_starve_ctr #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .rst     (rst),
      .ld_req  (ld_req),
      .ld_gnt  (ld_gnt),
      .force_ld(force_ld)
   );

`ifdef IMEM_WR_PROTECT_EN
   logic lock_d, err_q;
`endif

   always_comb begin
      fetch_gnt = 1'b0;
      ld_gnt    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = fetch_idx;
      mem_wdata = ld_wdata;
      owner_d   = NONE;
`ifdef IMEM_WR_PROTECT_EN
      lock_d    = 1'b0;
`endif
      if (force_ld)       ld_gnt    = 1'b1;
      else if (fetch_req) fetch_gnt = 1'b1;
      else if (ld_req)    ld_gnt    = 1'b1;

      if (fetch_gnt) begin
         if (fetch_mis) begin
            owner_d = FETCH_MIS;
         end else begin
            mem_en  = 1'b1;
            owner_d = FETCH;
         end
      end

      if (ld_gnt) begin
         mem_addr = ld_idx;
         mem_en   = 1'b1;
         mem_we   = ld_we;
         owner_d  = ld_we ? LD_WR : LD_RD;
`ifdef IMEM_WR_PROTECT_EN
         // A locked write still gets a response slot, but never reaches the RAM.
         if (ld_we && wr_lock) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
            lock_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= NONE;
`ifdef IMEM_WR_PROTECT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         owner_q <= owner_d;
`ifdef IMEM_WR_PROTECT_EN
         err_q   <= lock_d;
`endif
      end
   end

   assign fetch_rvalid = (owner_q == FETCH) || (owner_q == FETCH_MIS);
   assign fetch_err    = (owner_q == FETCH_MIS);
   assign fetch_rdata  = (owner_q == FETCH)     ? mem_rdata :
                         (owner_q == FETCH_MIS) ? NOP_INSTR : '0;
   assign ld_rvalid    = (owner_q == LD_RD) || (owner_q == LD_WR);
   assign ld_rdata     = (owner_q == LD_RD) ? mem_rdata : '0;
`ifdef IMEM_WR_PROTECT_EN
   assign ld_err       = err_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter with a behavioural 1-cycle RAM.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req, fetch_gnt, fetch_rvalid, fetch_err;
   logic [31:0] fetch_addr, fetch_rdata;
   logic        ld_req, ld_we, ld_gnt, ld_rvalid;
   logic [31:0] ld_addr, ld_wdata, ld_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
`ifdef IMEM_WR_PROTECT_EN
   logic        wr_lock, ld_err;
`endif

   imem_arbiter #(
      .DEPTH_WORDS(1024),
      .STARVE_MAX (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_gnt   (fetch_gnt),
      .fetch_rvalid(fetch_rvalid),
      .fetch_rdata (fetch_rdata),
      .fetch_err   (fetch_err),
      .ld_req      (ld_req),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_wdata    (ld_wdata),
      .ld_gnt      (ld_gnt),
      .ld_rvalid   (ld_rvalid),
      .ld_rdata    (ld_rdata),
`ifdef IMEM_WR_PROTECT_EN
      .wr_lock     (wr_lock),
      .ld_err      (ld_err),
`endif
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [0:1023];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct {
      logic [31:0] data;
      logic        err;
   } resp_t;

   resp_t fq[$];
   resp_t lq[$];
   int    tests = 0;
   int    fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, {31'b0, act}, {31'b0, exp});
   endtask

   resp_t fe, le;
   always @(negedge clk) begin
      if (fetch_rvalid) begin
         if (fq.size() == 0) begin
            tests++; fails++;
            $display("FAIL fetch_unexpected: got rvalid=1 expected none");
         end else begin
            fe = fq.pop_front();
            check("fetch_rdata", fetch_rdata, fe.data);
            check1("fetch_err", fetch_err, fe.err);
         end
      end
      if (ld_rvalid) begin
         if (lq.size() == 0) begin
            tests++; fails++;
            $display("FAIL ld_unexpected: got rvalid=1 expected none");
         end else begin
            le = lq.pop_front();
            check("ld_rdata", ld_rdata, le.data);
`ifdef IMEM_WR_PROTECT_EN
            check1("ld_err", ld_err, le.err);
`endif
         end
      end
   end

   task automatic fetch_once(input logic [31:0] addr, input logic [31:0] exp, input logic err);
      int n = 0;
      fetch_req = 1'b1; fetch_addr = addr;
      @(negedge clk);
      while (!fetch_gnt && n < 20) begin @(negedge clk); n++; end
      if (!fetch_gnt) begin
         tests++; fails++;
         $display("FAIL fetch_grant_timeout: got no grant expected grant");
      end else fq.push_back('{exp, err});
      @(posedge clk); #1;
      fetch_req = 1'b0;
   endtask

   task automatic ld_once(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input logic err);
      int n = 0;
      ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
      @(negedge clk);
      while (!ld_gnt && n < 20) begin @(negedge clk); n++; end
      if (!ld_gnt) begin
         tests++; fails++;
         $display("FAIL ld_grant_timeout: got no grant expected grant");
      end else lq.push_back('{exp, err});
      @(posedge clk); #1;
      ld_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      ram[0] = 32'h0050_0093;
      ram[1] = 32'h00a0_0113;
      ram[2] = 32'h0020_81b3;
      ram[8] = 32'hCAFE_F00D;
      rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
`ifdef IMEM_WR_PROTECT_EN
      wr_lock = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check1("rst_fetch_rvalid", fetch_rvalid, 1'b0);
      check1("rst_ld_rvalid", ld_rvalid, 1'b0);
      check1("rst_fetch_err", fetch_err, 1'b0);
      check("rst_fetch_rdata", fetch_rdata, 32'h0);
      check("rst_ld_rdata", ld_rdata, 32'h0);
      check1("rst_mem_en", mem_en, 1'b0);
      check1("rst_fetch_gnt", fetch_gnt, 1'b0);
      check1("rst_ld_gnt", ld_gnt, 1'b0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      fetch_once(32'h0, 32'h0050_0093, 1'b0);
      fetch_once(32'h4, 32'h00a0_0113, 1'b0);
      fetch_once(32'h8, 32'h0020_81b3, 1'b0);

      fetch_req = 1'b1; fetch_addr = 32'h6;
      @(negedge clk);
      check1("mis_fetch_gnt", fetch_gnt, 1'b1);
      check1("mis_mem_en", mem_en, 1'b0);
      fq.push_back('{32'h0000_0013, 1'b1});
      @(posedge clk); #1;
      fetch_req = 1'b0;

      ld_once(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      ld_once(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
      fetch_once(32'h10, 32'hDEAD_BEEF, 1'b0);
      fetch_once(32'h1010, 32'hDEAD_BEEF, 1'b0);
      ld_once(1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF, 1'b0);

`ifdef IMEM_WR_PROTECT_EN
      wr_lock = 1'b1;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h1234_5678;
      @(negedge clk);
      check1("lock_ld_gnt", ld_gnt, 1'b1);
      check1("lock_mem_we", mem_we, 1'b0);
      check1("lock_mem_en", mem_en, 1'b0);
      lq.push_back('{32'h0, 1'b1});
      @(posedge clk); #1;
      ld_req = 1'b0; wr_lock = 1'b0;
      ld_once(1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);
`endif
      repeat (2) @(posedge clk); #1;

      // Reset while the third fetch response is in flight; loader starvation count is nonzero.
      fetch_req = 1'b1; fetch_addr = 32'h0;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h4;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check1("pre_rst_fetch_gnt", fetch_gnt, 1'b1);
         if (c < 3) fq.push_back('{32'h0050_0093, 1'b0});
      end
      #1 rst = 1'b1;
      @(negedge clk);
      check1("mid_rst_fetch_rvalid", fetch_rvalid, 1'b0);
      check1("mid_rst_ld_rvalid", ld_rvalid, 1'b0);
      check("mid_rst_fetch_rdata", fetch_rdata, 32'h0);
      #1 rst = 1'b0;
      #1;
      check1("cont_c1_fetch_gnt", fetch_gnt, 1'b1);
      check1("cont_c1_ld_gnt", ld_gnt, 1'b0);
      fq.push_back('{32'h0050_0093, 1'b0});
      for (int c = 2; c <= 18; c++) begin
         @(negedge clk);
         check1("cont_fetch_gnt", fetch_gnt, (c % 9) != 0);
         check1("cont_ld_gnt", ld_gnt, (c % 9) == 0);
         if (fetch_gnt) fq.push_back('{32'h0050_0093, 1'b0});
         if (ld_gnt)    lq.push_back('{32'h00a0_0113, 1'b0});
      end
      @(posedge clk); #1;
      fetch_req = 1'b0; ld_req = 1'b0;
      repeat (3) @(negedge clk);
      check("fetch_queue_drained", fq.size(), 32'd0);
      check("ld_queue_drained", lq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
